// File: rtl/cmp_pkg.sv
// Shared types and defaults for the sequential magnitude comparator.
// The slices() helper keeps the slice-count derivation in one place.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DIGIT = 4;

  function automatic int slices(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational DIGIT-bit unsigned comparator with optional MSB inversion,
// used to bias the top slice so two's-complement operands order as unsigned.
module cmp_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             invert_msb,
  output logic             gt,
  output logic             lt
);

  logic [DIGIT-1:0] msbMask;
  logic [DIGIT-1:0] xBiased;
  logic [DIGIT-1:0] yBiased;

  assign msbMask = DIGIT'(invert_msb) << (DIGIT - 1);
  assign xBiased = x ^ msbMask;
  assign yBiased = y ^ msbMask;
  assign gt      = (xBiased > yBiased);
  assign lt      = (xBiased < yBiased);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB slice first and
// stops at the first differing slice, reporting through a start/busy/done handshake.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int NSLICE = slices(WIDTH, DIGIT);
  localparam int CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNTW-1:0] LAST_SLICE = CNTW'(NSLICE - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
      $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT and at least 2");
    end
  endgenerate

  cmp_state_t       state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic             signed_q;
  logic [CNTW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             greater_q;
  logic             less_q;
  logic             equal_q;

  logic             sliceGt;
  logic             sliceLt;
  logic             sliceInvert;

  // Sign bias only applies to the slice holding the operand sign bits.
  assign sliceInvert = signed_q & (cnt_q == '0);

  cmp_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x          (aShift_q[WIDTH-1 -: DIGIT]),
    .y          (bShift_q[WIDTH-1 -: DIGIT]),
    .invert_msb (sliceInvert),
    .gt         (sliceGt),
    .lt         (sliceLt)
  );

  // DONE behaves like IDLE for start acceptance so comparisons can run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aShift_q  <= '0;
      bShift_q  <= '0;
      signed_q  <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= RUN;
            aShift_q  <= a;
            bShift_q  <= b;
            signed_q  <= signed_mode;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (sliceGt || sliceLt) begin
            greater_q <= sliceGt;
            less_q    <= sliceLt;
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (cnt_q == LAST_SLICE) begin
            equal_q <= 1'b1;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            aShift_q <= aShift_q << DIGIT;
            bShift_q <= bShift_q << DIGIT;
            cnt_q    <= cnt_q + CNTW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign greater = greater_q;
  assign less    = less_q;
  assign equal   = equal_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=8, DIGIT=4): the driver
// queues hand-computed results, a monitor pops and compares them on each done.
module tb_seq_magnitude_comparator;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signedMode;
  logic         busy;
  logic         done;
  logic         greater;
  logic         less;
  logic         equal;

  typedef struct {
    logic [2:0] flags;
    int         edgeNo;
    string      name;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] av;
    logic [7:0] bv;
    logic       sm;
    logic [2:0] flags;
    int         lat;
  } vec_t;

  exp_t expQ[$];
  exp_t curExp;
  int   edgeCount = 0;
  int   errors    = 0;
  int   checks    = 0;

  seq_magnitude_comparator #(
    .WIDTH (W),
    .DIGIT (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signedMode),
    .busy        (busy),
    .done        (done),
    .greater     (greater),
    .less        (less),
    .equal       (equal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        curExp = expQ.pop_front();
        checkOutput({curExp.name, "_flags"}, {29'b0, greater, less, equal}, {29'b0, curExp.flags});
        checkOutput({curExp.name, "_latency"}, edgeCount, curExp.edgeNo);
        checkOutput({curExp.name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  // Drives start for one edge; lat counts cycles from the accepting edge to the done cycle.
  task automatic applyStimulus(input string name, input logic [7:0] av, input logic [7:0] bv,
                               input logic sm, input logic [2:0] flags, input int lat,
                               input bit push);
    exp_t e;
    start      = 1'b1;
    a          = av;
    b          = bv;
    signedMode = sm;
    @(posedge clk);
    #1;
    if (push) begin
      e.flags  = flags;
      e.edgeNo = edgeCount + lat - 1;
      e.name   = name;
      expQ.push_back(e);
    end
    checkOutput({name, "_after_start"}, {27'b0, busy, done, greater, less, equal}, 32'b10000);
    @(negedge clk);
    start      = 1'b0;
    a          = W'($urandom);
    b          = W'($urandom);
    signedMode = 1'($urandom);
  endtask

  task automatic waitIdle(input string name, input logic [2:0] flags);
    bit drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (expQ.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      checkOutput({name, "_timeout"}, expQ.size(), 32'd0);
      expQ.delete();
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_hold"}, {27'b0, busy, done, greater, less, equal}, {27'b0, 2'b00, flags});
  endtask

  vec_t vecs[] = '{
    '{"u_gt_slice0",  8'hA3, 8'h53, 1'b0, 3'b100, 2},
    '{"u_lt_slice1",  8'h35, 8'h3A, 1'b0, 3'b010, 3},
    '{"u_eq",         8'h7E, 8'h7E, 1'b0, 3'b001, 3},
    '{"s_eq",         8'h7E, 8'h7E, 1'b1, 3'b001, 3},
    '{"s_lt_minneg",  8'h80, 8'h01, 1'b1, 3'b010, 2},
    '{"u_gt_80",      8'h80, 8'h01, 1'b0, 3'b100, 2},
    '{"s_gt_minus1",  8'h7F, 8'hFF, 1'b1, 3'b100, 2},
    '{"u_lt_7f",      8'h7F, 8'hFF, 1'b0, 3'b010, 2},
    '{"s_gt_slice1",  8'h08, 8'h07, 1'b1, 3'b100, 3}
  };

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    a          = '0;
    b          = '0;
    signedMode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {27'b0, busy, done, greater, less, equal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].av, vecs[i].bv, vecs[i].sm, vecs[i].flags, vecs[i].lat, 1'b1);
      waitIdle(vecs[i].name, vecs[i].flags);
    end

    // A second start while RUN must not disturb the first comparison.
    applyStimulus("ign_first", 8'h35, 8'h3A, 1'b0, 3'b010, 3, 1'b1);
    applyStimulus("ign_second", 8'hFF, 8'h00, 1'b0, 3'b100, 3, 1'b0);
    waitIdle("ign", 3'b010);

    // Back-to-back: restart in the done cycle, flags clear on acceptance.
    applyStimulus("b2b_first", 8'hA3, 8'h53, 1'b0, 3'b100, 2, 1'b1);
    @(negedge clk);
    applyStimulus("b2b_second", 8'h12, 8'h13, 1'b0, 3'b010, 3, 1'b1);
    waitIdle("b2b", 3'b010);

    // Reset in cycle 1 aborts a 3-cycle compare with no done pulse.
    applyStimulus("abort", 8'h35, 8'h3A, 1'b0, 3'b010, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_outputs", {27'b0, busy, done, greater, less, equal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_idle", {27'b0, busy, done, greater, less, equal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
